wb_byte_ram: RTL and testbench
==============================

Name: wb_byte_ram

Overview:
- Single-port synchronous RAM that acts as a Wishbone classic slave with byte-lane write enables.
- It is the program/data memory for the ao68000 CPU in the point-to-point CPU+RAM system.
- Word-organised storage array named `mem`, so simulation can preload it with a word-per-line hex image.
- Responds to every address in its window with a registered single-cycle acknowledge.

Parameters:
- DW, 32: data bus width in bits; must be 8*SW.
- AW, 20: byte-address width; capacity is 2^AW bytes.
- SW, 4: number of byte-select lanes.
- Parameters are also accepted positionally in the order DW, AW, SW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- adr_i  input  AW  byte address; word index = adr_i[AW-1:log2(SW)]; low log2(SW) bits ignored.
- dat_i  input  DW  write data.
- dat_o  output  DW  read data, registered.
- we_i  input  1  1 = write, 0 = read.
- sel_i  input  SW  byte-lane enables; lane i = data bits [8i+7:8i].
- stb_i  input  1  strobe.
- cyc_i  input  1  bus cycle valid.
- ack_o  output  1  transfer acknowledge, registered.

Behaviour:
- Storage:
  - `mem` has depth 2^AW/SW words, each DW bits wide, indexed by word address.
  - No bounds check is needed, since every word index is in range.
  - Address bits of the master above AW are not connected (aliasing is intended).
- Reset (asynchronous, rst_n=0):
  - ack_o=0 and dat_o=0 immediately.
  - `mem` contents are NOT cleared, so a preloaded image survives reset.
- Request:
  - A rising edge with rst_n=1 and cyc_i & stb_i & ~ack_o is an accepted request.
- On an accepted request, at that same edge:
  - ack_o <= 1.
  - dat_o <= mem[word] (value before any write on this edge).
  - If we_i=1, for each i with sel_i[i]=1: mem[word][8i+7:8i] <= dat_i[8i+7:8i]. Unselected lanes are unchanged.
- Every other rising edge: ack_o <= 0 and dat_o holds its value.
- Consequences:
  - ack_o is high for exactly one cycle.
  - Latency is one wait state: request seen at edge N, ack_o high during cycle N..N+1.
  - With stb_i held continuously the ack pattern is 0,1,0,1,...; each ack is a separate transfer.
- Reads:
  - Always return the full word regardless of sel_i; the master picks its lanes.
  - sel_i=0 on a write completes with ack and modifies nothing.
- Byte order is not interpreted by the RAM.
  - For the 68000 (big-endian), the byte at the lowest address sits in bits [31:24] (sel_i[3]).
  - Hex images are written with that convention.
- Abort: if cyc_i or stb_i drops while ack_o is high, the transfer (including the write) is already complete and ack_o still falls next edge.
- Reset mid-transfer:
  - If rst_n falls before the accepting edge, no write occurs and ack_o stays 0.
  - If rst_n falls while ack_o is high, ack_o clears immediately; any write already committed stays committed.
- dat_o is meaningful only while ack_o=1.
- No ERR/RTY generation; the system ties those inputs of the master inactive.

Test Plan:
- Preload via $readmemh with mem[0]=0x00001000 and mem[1]=0x00000008; read adr 0x00000 then 0x00004 -> dat_o=0x00001000 then 0x00000008, each with ack_o one cycle after the accepting edge.
- Write 0xDEADBEEF to adr 0x00010 with sel=1111, then read adr 0x00010 -> 0xDEADBEEF.
- Write dat_i=0x0000AA00 to adr 0x00010 with sel=0010, then read -> 0xDEADAAEF.
- Hold cyc=stb=1, we=0 for 6 cycles -> ack_o sequence 0,1,0,1,0,1.
- Read adr 0x00013 -> same word as 0x00010 (low bits ignored).
- Assert rst_n=0 while ack_o=1 -> ack_o=0 and dat_o=0 immediately; after release, reading 0x00010 still returns 0xDEADAAEF.

Source files
------------

// File: rtl/wb_byte_ram.sv
// rtl/wb_byte_ram.sv - Wishbone classic single-port RAM with byte-lane writes
//
// Word-organised synchronous RAM acting as a Wishbone classic slave. Every
// request inside the window gets a registered acknowledge after one wait
// state. The storage array `mem` is never cleared by reset, so an image
// preloaded for simulation survives reset.
//
// Parameters:
//   DW  data bus width in bits (must equal 8*SW)
//   AW  byte-address width, capacity 2^AW bytes
//   SW  number of byte-select lanes
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (clears ack_o and dat_o only)
//   adr_i  byte address; low log2(SW) bits ignored
//   dat_i  write data
//   dat_o  registered read data, valid while ack_o=1
//   we_i   1 = write, 0 = read
//   sel_i  byte-lane enables, lane i = bits [8i+7:8i]
//   stb_i  strobe
//   cyc_i  bus cycle valid
//   ack_o  registered single-cycle transfer acknowledge

module wb_byte_ram #(
    parameter int DW = 32,
    parameter int AW = 20,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    input  logic          we_i,
    input  logic [SW-1:0] sel_i,
    input  logic          stb_i,
    input  logic          cyc_i,
    output logic          ack_o
);

    localparam int LSB   = $clog2(SW);
    localparam int WAW   = AW - LSB;
    localparam int DEPTH = 1 << WAW;

    logic [DW-1:0]  mem [0:DEPTH-1];
    logic [WAW-1:0] word;
    logic           req;

    assign word = adr_i[AW-1:LSB];

    // The ~ack_o term splits back-to-back strobes into separate transfers,
    // giving the 0,1,0,1 ack pattern when stb_i is held high.
    assign req = cyc_i & stb_i & ~ack_o;

    generate
        if (LSB > 0) begin : g_lsb_unused
            logic unused_lsb;
            assign unused_lsb = ^adr_i[LSB-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else if (req) begin
            ack_o <= 1'b1;
            dat_o <= mem[word];
        end else begin
            ack_o <= 1'b0;
        end
    end

    // Storage has no reset. rst_n gates writes so a request that is still
    // being presented while reset is asserted commits nothing.
    always_ff @(posedge clk) begin
        if (rst_n && req && we_i) begin
            for (int i = 0; i < SW; i++) begin
                if (sel_i[i]) begin
                    mem[word][8*i +: 8] <= dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_byte_ram.sv
// tb/tb_wb_byte_ram.sv - self-checking bench for wb_byte_ram

module tb_wb_byte_ram;

    logic        clk;
    logic        rst_n;
    logic [19:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;

    int n_total = 0;
    int n_pass  = 0;

    wb_byte_ram #(.DW(32), .AW(20), .SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .sel_i (sel_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .ack_o (ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [19:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_dat;
        logic [31:0] exp_dat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_bus();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        sel_i = 4'h0;
        adr_i = '0;
        dat_i = '0;
    endtask

    // One transfer: drive on the falling edge, check ack and data just after
    // the accepting edge, then confirm ack falls one cycle later.
    task automatic xfer(input vec_t v);
        @(negedge clk);
        adr_i = v.adr;
        dat_i = v.dat;
        we_i  = v.we;
        sel_i = v.sel;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        check({v.name, " ack_before"}, {31'd0, ack_o}, 32'd0);
        @(posedge clk);
        #1;
        check({v.name, " ack"}, {31'd0, ack_o}, 32'd1);
        if (v.chk_dat) check({v.name, " dat"}, dat_o, v.exp_dat);
        idle_bus();
        @(posedge clk);
        #1;
        check({v.name, " ack_fall"}, {31'd0, ack_o}, 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic chk, input logic [31:0] exp,
                                input string name);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.chk_dat = chk; v.exp_dat = exp; v.name = name;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_bus();

        // Preloaded image (word-per-line convention).
        dut.mem[0] = 32'h0000_1000;
        dut.mem[1] = 32'h0000_0008;
        dut.mem[8] = 32'h1234_5678;
        dut.mem[9] = 32'h1122_3344;

        #2;
        check("reset ack", {31'd0, ack_o}, 32'd0);
        check("reset dat", dat_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(mk(1'b0, 20'h00000, 32'h0, 4'hF, 1'b1, 32'h0000_1000, "rd0"));
        vecs.push_back(mk(1'b0, 20'h00004, 32'h0, 4'hF, 1'b1, 32'h0000_0008, "rd4"));
        vecs.push_back(mk(1'b1, 20'h00010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "wr_full"));
        vecs.push_back(mk(1'b0, 20'h00010, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, "rd_full"));
        vecs.push_back(mk(1'b1, 20'h00010, 32'h0000_AA00, 4'h2, 1'b1, 32'hDEAD_BEEF, "wr_lane1_old"));
        vecs.push_back(mk(1'b0, 20'h00010, 32'h0, 4'h1, 1'b1, 32'hDEAD_AAEF, "rd_lane1"));
        vecs.push_back(mk(1'b0, 20'h00013, 32'h0, 4'h0, 1'b1, 32'hDEAD_AAEF, "rd_lowbits"));
        vecs.push_back(mk(1'b1, 20'h00020, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h1234_5678, "wr_sel0"));
        vecs.push_back(mk(1'b0, 20'h00020, 32'h0, 4'hF, 1'b1, 32'h1234_5678, "rd_sel0"));
        vecs.push_back(mk(1'b1, 20'h00024, 32'hAABB_CCDD, 4'h9, 1'b1, 32'h1122_3344, "wr_lanes03"));
        vecs.push_back(mk(1'b0, 20'h00026, 32'h0, 4'hF, 1'b1, 32'hAA22_33DD, "rd_lanes03"));

        foreach (vecs[i]) xfer(vecs[i]);

        // Continuous strobe: ack toggles 0,1,0,1,0,1 at successive samples.
        @(negedge clk);
        adr_i = 20'h00010;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stream ack[%0d]", k), {31'd0, ack_o}, 32'(k % 2));
            if (k % 2 == 1) check($sformatf("stream dat[%0d]", k), dat_o, 32'hDEAD_AAEF);
            @(negedge clk);
        end
        idle_bus();
        @(negedge clk);

        // Abort while ack is high: the write is already committed.
        adr_i = 20'h00030;
        dat_i = 32'hCAFE_F00D;
        we_i  = 1'b1;
        sel_i = 4'hF;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        @(posedge clk);
        #1;
        idle_bus();
        #1;
        check("abort ack held", {31'd0, ack_o}, 32'd1);
        @(posedge clk);
        #1;
        check("abort ack fall", {31'd0, ack_o}, 32'd0);
        xfer(mk(1'b0, 20'h00030, 32'h0, 4'hF, 1'b1, 32'hCAFE_F00D, "abort rd"));

        // Reset before the accepting edge: nothing is written, no ack.
        @(negedge clk);
        rst_n = 1'b0;
        adr_i = 20'h00010;
        dat_i = 32'h5555_5555;
        we_i  = 1'b1;
        sel_i = 4'hF;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pre ack", {31'd0, ack_o}, 32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while ack is high clears ack/dat at once; memory survives.
        @(negedge clk);
        adr_i = 20'h00010;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid ack before", {31'd0, ack_o}, 32'd1);
        check("rst_mid dat before", dat_o, 32'hDEAD_AAEF);
        rst_n = 1'b0;
        #1;
        check("rst_mid ack", {31'd0, ack_o}, 32'd0);
        check("rst_mid dat", dat_o, 32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        xfer(mk(1'b0, 20'h00010, 32'h0, 4'hF, 1'b1, 32'hDEAD_AAEF, "post_rst rd"));
        xfer(mk(1'b0, 20'h00000, 32'h0, 4'hF, 1'b1, 32'h0000_1000, "post_rst img"));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
